// File: rtl/dma_pkg.sv
// ----------------------------------------------------------------------------
// dma_pkg
// Shared types and constants for the DMA transfer engine.
//   state_t      : transfer FSM states
//   NUM_CH       : channel count (4)
//   ADDR_W       : physical bus address width (48)
//   WORD_BYTES   : bytes per transferred word (8)
//   span_exceeds : true when base + 8*words runs past the top of the
//                  48-bit address space
// ----------------------------------------------------------------------------
package dma_pkg;

    localparam int NUM_CH     = 4;
    localparam int ADDR_W     = 48;
    localparam int WORD_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        WRITE,
        DONE
    } state_t;

    // One bit wider than the address so the end of a transfer that lands
    // exactly on 2^48 is still legal while anything beyond is caught.
    function automatic logic span_exceeds(input logic [ADDR_W-1:0] base,
                                          input logic [15:0]       words);
        logic [ADDR_W:0] w_end;
        w_end = {1'b0, base} + {{(ADDR_W-18){1'b0}}, words, 3'b000};
        return w_end > {1'b1, {ADDR_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dma_xfer_engine_if.sv
// ----------------------------------------------------------------------------
// dma_xfer_engine_if
// Single-master memory port used by the DMA transfer engine.
//   mem_addr  : byte address            (master -> slave)
//   mem_wdata : write data              (master -> slave)
//   mem_re    : read request            (master -> slave)
//   mem_we    : write request           (master -> slave)
//   mem_rdata : read data, valid w/ ack (slave -> master)
//   mem_ack   : request accepted        (slave -> master)
// ----------------------------------------------------------------------------
interface dma_xfer_engine_if;
    import dma_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;
    logic              mem_re;
    logic              mem_we;
    logic              mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_re, mem_we,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_re, mem_we,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/dma_rr_arb.sv
// ----------------------------------------------------------------------------
// dma_rr_arb
// Combinational 4-way round-robin arbiter.
//   req       : pending request per channel
//   ptr       : highest-priority channel for this decision
//   gnt_idx   : winning channel index
//   gnt_valid : at least one request present
// ----------------------------------------------------------------------------
module dma_rr_arb (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    logic [1:0] w_idx;

    // Scan from farthest to nearest so the channel closest to ptr wins.
    always_comb begin
        gnt_idx   = ptr;
        gnt_valid = 1'b0;
        w_idx     = ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = ptr + 2'(k);
            if (req[w_idx]) begin
                gnt_idx   = w_idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_xfer_engine.sv
// ----------------------------------------------------------------------------
// dma_xfer_engine
// Four-channel DMA copy engine: round-robin picks a pending channel, then
// copies size 64-bit words from src to dest one read/write pair at a time.
//   clk, rst            : clock, synchronous active-high reset
//   ch_start            : per-channel start pulse
//   ch_src / ch_dest    : per-channel 64-bit byte addresses (packed)
//   ch_size             : per-channel word count (packed, 16 bits each)
//   ch_busy             : channel pending or being serviced
//   ch_done             : one-cycle completion pulse
//   ch_err              : sticky error, cleared by next accepted start
//   mem                 : memory master port
//
// state | meaning
// IDLE  | waiting for a pending channel
// LOAD  | snapshot channel registers, validate the request
// READ  | read request at cur_src outstanding
// WRITE | write request at cur_dest outstanding
// DONE  | completion pulse, advance the round-robin pointer
// ----------------------------------------------------------------------------
module dma_xfer_engine
    import dma_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    ch_start,
    input  logic [NUM_CH*64-1:0] ch_src,
    input  logic [NUM_CH*64-1:0] ch_dest,
    input  logic [NUM_CH*16-1:0] ch_size,
    output logic [NUM_CH-1:0]    ch_busy,
    output logic [NUM_CH-1:0]    ch_done,
    output logic [NUM_CH-1:0]    ch_err,
    dma_xfer_engine_if.master    mem
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

    state_t              r_state;
    logic [NUM_CH-1:0]   r_pending;
    logic [NUM_CH-1:0]   r_active;
    logic [NUM_CH-1:0]   r_done;
    logic [NUM_CH-1:0]   r_err;
    logic [1:0]          r_gnt;
    logic [1:0]          r_ptr;
    logic [ADDR_W-1:0]   r_cur_src;
    logic [ADDR_W-1:0]   r_cur_dest;
    logic [15:0]         r_remaining;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [63:0]         r_mem_wdata;
    logic                r_mem_re;
    logic                r_mem_we;

    logic [1:0]          w_gnt_idx;
    logic                w_gnt_valid;
    logic [NUM_CH-1:0]   w_accept;
    logic [63:0]         w_src;
    logic [63:0]         w_dest;
    logic [15:0]         w_size;
    logic                w_load_err;

    assign ch_busy  = r_pending | r_active;
    assign ch_done  = r_done;
    assign ch_err   = r_err;
    assign w_accept = ch_start & ~ch_busy;

    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign mem.mem_re    = r_mem_re;
    assign mem.mem_we    = r_mem_we;

    assign w_src  = ch_src[{r_gnt, 6'd0} +: 64];
    assign w_dest = ch_dest[{r_gnt, 6'd0} +: 64];
    assign w_size = ch_size[{r_gnt, 4'd0} +: 16];

    assign w_load_err = (w_src[2:0] != 3'd0) || (w_dest[2:0] != 3'd0) ||
                        (|w_src[63:48]) || (|w_dest[63:48]) ||
                        span_exceeds(w_src[ADDR_W-1:0], w_size) ||
                        span_exceeds(w_dest[ADDR_W-1:0], w_size);

    dma_rr_arb u_arb (
        .req       (r_pending),
        .ptr       (r_ptr),
        .gnt_idx   (w_gnt_idx),
        .gnt_valid (w_gnt_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_active    <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_gnt       <= '0;
            r_ptr       <= '0;
            r_cur_src   <= '0;
            r_cur_dest  <= '0;
            r_remaining <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            r_done    <= '0;
            r_pending <= r_pending | w_accept;
            r_err     <= r_err & ~w_accept;

            // The granted channel is always busy, so the per-bit updates
            // below never collide with a start on the same channel.
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt                <= w_gnt_idx;
                        r_pending[w_gnt_idx] <= 1'b0;
                        r_active[w_gnt_idx]  <= 1'b1;
                        r_state              <= LOAD;
                    end
                end
                LOAD: begin
                    r_cur_src   <= w_src[ADDR_W-1:0];
                    r_cur_dest  <= w_dest[ADDR_W-1:0];
                    r_remaining <= w_size;
                    if (w_size == 16'd0) begin
                        r_done[r_gnt] <= 1'b1;
                        r_state       <= DONE;
                    end else if (w_load_err) begin
                        r_done[r_gnt] <= 1'b1;
                        r_err[r_gnt]  <= 1'b1;
                        r_state       <= DONE;
                    end else begin
                        r_mem_re   <= 1'b1;
                        r_mem_addr <= w_src[ADDR_W-1:0];
                        r_state    <= READ;
                    end
                end
                READ: begin
                    if (mem.mem_ack) begin
                        r_mem_re    <= 1'b0;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_cur_dest;
                        r_mem_wdata <= mem.mem_rdata;
                        r_state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem.mem_ack) begin
                        r_mem_we    <= 1'b0;
                        r_cur_src   <= r_cur_src + STEP;
                        r_cur_dest  <= r_cur_dest + STEP;
                        r_remaining <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            r_done[r_gnt] <= 1'b1;
                            r_state       <= DONE;
                        end else begin
                            r_mem_re   <= 1'b1;
                            r_mem_addr <= r_cur_src + STEP;
                            r_state    <= READ;
                        end
                    end
                end
                DONE: begin
                    r_active <= '0;
                    r_ptr    <= r_gnt + 2'd1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_xfer_engine.sv
// ----------------------------------------------------------------------------
// tb_dma_xfer_engine
// Directed bench for dma_xfer_engine with a behavioural memory responder
// (configurable ack delay, read data derived from the address).
// ----------------------------------------------------------------------------
module tb_dma_xfer_engine;
    import dma_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   ch_start;
    logic [255:0] ch_src;
    logic [255:0] ch_dest;
    logic [63:0]  ch_size;
    logic [3:0]   ch_busy;
    logic [3:0]   ch_done;
    logic [3:0]   ch_err;

    dma_xfer_engine_if mem ();

    dma_xfer_engine dut (
        .clk      (clk),
        .rst      (rst),
        .ch_start (ch_start),
        .ch_src   (ch_src),
        .ch_dest  (ch_dest),
        .ch_size  (ch_size),
        .ch_busy  (ch_busy),
        .ch_done  (ch_done),
        .ch_err   (ch_err),
        .mem      (mem)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [47:0] addr;
        logic [63:0] data;
    } acc_t;

    int   checks    = 0;
    int   failures  = 0;
    int   edge_cnt  = 0;
    int   t0        = 0;
    int   ack_delay = 0;
    int   wait_cnt  = 0;
    int   done_edge [4];
    int   done_cnt  [4];
    acc_t log_q [$];

    logic        held      = 1'b0;
    logic        held_we   = 1'b0;
    logic [47:0] held_addr = '0;
    logic [63:0] held_data = '0;

    function automatic logic [63:0] pat(input logic [47:0] a);
        return {a, 16'hA5C3};
    endfunction

    assign mem.mem_rdata = mem.mem_re ? pat(mem.mem_addr) : 64'h0;
    assign mem.mem_ack   = (mem.mem_re | mem.mem_we) && (wait_cnt >= ack_delay);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_acc(input string tag, input int idx, input logic we,
                           input logic [47:0] addr, input logic [63:0] data);
        acc_t exp_a;
        acc_t obs_a;
        exp_a = {we, addr, data};
        obs_a = (idx < log_q.size()) ? log_q[idx] : '0;
        checks++;
        assert (obs_a === exp_a)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs_a, exp_a);
        end
    endtask

    // Memory responder: logs every accepted access and checks that a
    // stalled request keeps its kind, address and data.
    always @(posedge clk) begin
        acc_t a;
        edge_cnt++;
        if (held) begin
            chk("hold_req", 64'(mem.mem_re | mem.mem_we), 64'd1);
            chk("hold_kind", 64'(mem.mem_we), 64'(held_we));
            chk("hold_addr", 64'(mem.mem_addr), 64'(held_addr));
            if (held_we) chk("hold_wdata", mem.mem_wdata, held_data);
        end
        held      = (mem.mem_re | mem.mem_we) && !mem.mem_ack && !rst;
        held_we   = mem.mem_we;
        held_addr = mem.mem_addr;
        held_data = mem.mem_wdata;
        if ((mem.mem_re | mem.mem_we) && mem.mem_ack) begin
            a = {mem.mem_we, mem.mem_addr, mem.mem_we ? mem.mem_wdata : mem.mem_rdata};
            log_q.push_back(a);
        end
        if ((mem.mem_re | mem.mem_we) && !mem.mem_ack) wait_cnt <= wait_cnt + 1;
        else                                           wait_cnt <= 0;
    end

    always @(negedge clk) begin
        chk("re_we_exclusive", 64'(mem.mem_re & mem.mem_we), 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (ch_done[i]) begin
                done_edge[i] = edge_cnt;
                done_cnt[i]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [63:0] s, input logic [63:0] d,
                          input logic [15:0] n);
        ch_src[64*c +: 64]  = s;
        ch_dest[64*c +: 64] = d;
        ch_size[16*c +: 16] = n;
    endtask

    task automatic pulse(input logic [3:0] m);
        ch_start = m;
        @(posedge clk);
        #1;
        t0       = edge_cnt;
        ch_start = 4'd0;
    endtask

    task automatic clr();
        log_q.delete();
        for (int i = 0; i < 4; i++) done_edge[i] = -1;
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 300; n++) begin
            if (ch_busy == 4'd0) break;
            tick();
        end
        chk(tag, 64'(ch_busy), 64'd0);
        tick();
        tick();
    endtask

    initial begin
        logic [63:0] e_src  [3];
        logic [63:0] e_dest [3];
        logic [15:0] e_size [3];
        int tb_base;
        int cnt0;
        int cnt1;
        int cnt3;
        int nlog;

        rst      = 1'b1;
        ch_start = 4'd0;
        ch_src   = '0;
        ch_dest  = '0;
        ch_size  = '0;
        for (int i = 0; i < 4; i++) done_cnt[i] = 0;
        clr();
        repeat (3) tick();

        chk("rst_busy", 64'(ch_busy), 64'd0);
        chk("rst_done", 64'(ch_done), 64'd0);
        chk("rst_err", 64'(ch_err), 64'd0);
        chk("rst_req", 64'({mem.mem_re, mem.mem_we}), 64'd0);
        chk("rst_addr", 64'(mem.mem_addr), 64'd0);
        chk("rst_wdata", mem.mem_wdata, 64'd0);
        rst = 1'b0;
        tick();

        // Basic 3-word copy on channel 0
        set_ch(0, 64'h1000, 64'h2000, 16'd3);
        clr();
        pulse(4'b0001);
        chk("t1_busy_rise", 64'(ch_busy), 64'h1);
        wait_idle("t1_idle");
        chk("t1_done_edge", 64'(done_edge[0] - t0), 64'd8);
        chk("t1_done_cnt", 64'(done_cnt[0]), 64'd1);
        chk("t1_err", 64'(ch_err), 64'd0);
        chk("t1_nacc", 64'(log_q.size()), 64'd6);
        for (int k = 0; k < 3; k++) begin
            chk_acc($sformatf("t1_rd%0d", k), 2*k, 1'b0, 48'h1000 + 48'(8*k),
                    pat(48'h1000 + 48'(8*k)));
            chk_acc($sformatf("t1_wr%0d", k), 2*k+1, 1'b1, 48'h2000 + 48'(8*k),
                    pat(48'h1000 + 48'(8*k)));
        end

        // Simultaneous starts on 1..3, then ch0 started while ch1 is active
        set_ch(1, 64'h3000, 64'h6000, 16'd1);
        set_ch(2, 64'h4000, 64'h6800, 16'd1);
        set_ch(3, 64'h5000, 64'h6C00, 16'd1);
        set_ch(0, 64'h7000, 64'h7800, 16'd1);
        clr();
        pulse(4'b1110);
        tb_base = t0;
        repeat (2) tick();
        pulse(4'b0001);
        wait_idle("t2_idle");
        chk("t2_done1", 64'(done_edge[1] - tb_base), 64'd4);
        chk("t2_done2", 64'(done_edge[2] - tb_base), 64'd9);
        chk("t2_done3", 64'(done_edge[3] - tb_base), 64'd14);
        chk("t2_done0", 64'(done_edge[0] - tb_base), 64'd19);
        chk("t2_nacc", 64'(log_q.size()), 64'd8);
        chk_acc("t2_rd_ch1", 0, 1'b0, 48'h3000, pat(48'h3000));
        chk_acc("t2_wr_ch1", 1, 1'b1, 48'h6000, pat(48'h3000));
        chk_acc("t2_rd_ch2", 2, 1'b0, 48'h4000, pat(48'h4000));
        chk_acc("t2_rd_ch3", 4, 1'b0, 48'h5000, pat(48'h5000));
        chk_acc("t2_rd_ch0", 6, 1'b0, 48'h7000, pat(48'h7000));
        chk_acc("t2_wr_ch0", 7, 1'b1, 48'h7800, pat(48'h7000));

        // Channel 2: transfer ending exactly at 2^48 is legal
        set_ch(2, 64'hFFFF_FFFF_FFF8, 64'h8000, 16'd1);
        clr();
        pulse(4'b0100);
        wait_idle("t3_edge_idle");
        chk("t3_edge_done", 64'(done_edge[2] - t0), 64'd4);
        chk("t3_edge_err", 64'(ch_err), 64'd0);
        chk_acc("t3_edge_rd", 0, 1'b0, 48'hFFFF_FFFF_FFF8, pat(48'hFFFF_FFFF_FFF8));
        chk_acc("t3_edge_wr", 1, 1'b1, 48'h8000, pat(48'hFFFF_FFFF_FFF8));

        // Channel 2 error cases: misaligned src, dest above 48 bits, overrun
        e_src[0] = 64'h1004;            e_dest[0] = 64'h2000;                e_size[0] = 16'd1;
        e_src[1] = 64'h1000;            e_dest[1] = 64'h0001_0000_0000_0000; e_size[1] = 16'd1;
        e_src[2] = 64'hFFFF_FFFF_FFF8;  e_dest[2] = 64'h2000;                e_size[2] = 16'd2;
        for (int e = 0; e < 3; e++) begin
            set_ch(2, e_src[e], e_dest[e], e_size[e]);
            clr();
            pulse(4'b0100);
            chk($sformatf("t3_err%0d_cleared", e), 64'(ch_err[2]), 64'd0);
            wait_idle($sformatf("t3_err%0d_idle", e));
            chk($sformatf("t3_err%0d_done", e), 64'(done_edge[2] - t0), 64'd2);
            chk($sformatf("t3_err%0d_flag", e), 64'(ch_err), 64'h4);
            chk($sformatf("t3_err%0d_nacc", e), 64'(log_q.size()), 64'd0);
        end

        // size=0 completes without bus traffic
        set_ch(0, 64'h1000, 64'h2000, 16'd0);
        clr();
        pulse(4'b0001);
        wait_idle("t4_zero_idle");
        chk("t4_zero_done", 64'(done_edge[0] - t0), 64'd2);
        chk("t4_zero_err", 64'(ch_err[0]), 64'd0);
        chk("t4_zero_nacc", 64'(log_q.size()), 64'd0);

        // Starts while busy (mid-transfer and in the DONE cycle) are ignored
        set_ch(0, 64'h1000, 64'h2000, 16'd3);
        clr();
        cnt0 = done_cnt[0];
        pulse(4'b0001);
        tb_base = t0;
        repeat (2) tick();
        pulse(4'b0001);
        repeat (5) tick();
        chk("t4_done_at8", 64'(ch_done[0]), 64'd1);
        ch_start = 4'b0001;
        tick();
        ch_start = 4'd0;
        wait_idle("t4_rep_idle");
        chk("t4_rep_edge", 64'(done_edge[0] - tb_base), 64'd8);
        chk("t4_rep_cnt", 64'(done_cnt[0] - cnt0), 64'd1);
        chk("t4_rep_nacc", 64'(log_q.size()), 64'd6);

        // Three wait cycles on every access
        ack_delay = 3;
        set_ch(3, 64'h9000, 64'hA000, 16'd2);
        clr();
        pulse(4'b1000);
        wait_idle("t5_idle");
        chk("t5_done_edge", 64'(done_edge[3] - t0), 64'd18);
        chk("t5_nacc", 64'(log_q.size()), 64'd4);
        chk_acc("t5_rd0", 0, 1'b0, 48'h9000, pat(48'h9000));
        chk_acc("t5_wr0", 1, 1'b1, 48'hA000, pat(48'h9000));
        chk_acc("t5_rd1", 2, 1'b0, 48'h9008, pat(48'h9008));
        chk_acc("t5_wr1", 3, 1'b1, 48'hA008, pat(48'h9008));
        ack_delay = 0;

        // Reset while channel 1 is in WRITE and channel 3 is pending
        chk("t6_err_before", 64'(ch_err), 64'h4);
        set_ch(1, 64'hB000, 64'hC000, 16'd3);
        set_ch(3, 64'h9000, 64'hA000, 16'd1);
        clr();
        cnt1 = done_cnt[1];
        cnt3 = done_cnt[3];
        pulse(4'b0010);
        tick();
        pulse(4'b1000);
        tick();
        chk("t6_in_write", 64'({mem.mem_re, mem.mem_we}), 64'd1);
        chk("t6_busy_pre", 64'(ch_busy), 64'hA);
        rst = 1'b1;
        tick();
        chk("t6_rst_req", 64'({mem.mem_re, mem.mem_we}), 64'd0);
        chk("t6_rst_addr", 64'(mem.mem_addr), 64'd0);
        chk("t6_rst_wdata", mem.mem_wdata, 64'd0);
        chk("t6_rst_status", 64'({ch_busy, ch_done, ch_err}), 64'd0);
        rst  = 1'b0;
        nlog = log_q.size();
        repeat (6) tick();
        chk("t6_post_busy", 64'(ch_busy), 64'd0);
        chk("t6_post_done1", 64'(done_cnt[1] - cnt1), 64'd0);
        chk("t6_post_done3", 64'(done_cnt[3] - cnt3), 64'd0);
        chk("t6_post_nacc", 64'(log_q.size() - nlog), 64'd0);

        set_ch(1, 64'hD000, 64'hE000, 16'd1);
        clr();
        pulse(4'b0010);
        wait_idle("t6_again_idle");
        chk("t6_again_done", 64'(done_edge[1] - t0), 64'd4);
        chk("t6_again_err", 64'(ch_err), 64'd0);
        chk_acc("t6_again_rd", 0, 1'b0, 48'hD000, pat(48'hD000));
        chk_acc("t6_again_wr", 1, 1'b1, 48'hE000, pat(48'hD000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
